// File: rtl/rc4_ctrl_pkg.sv
// rc4_ctrl_pkg: shared types and constants for the rc4 keystream controller
package rc4_ctrl_pkg;
  localparam int KEY_SIZE = 8;
  localparam int CNT_W = 16;
  typedef enum logic [2:0] {IDLE, CRST, LOAD, RUN, DRAIN} state_e;
endpackage

// File: rtl/rc4_ks_fifo.sv
// rc4_ks_fifo: registered synchronous FIFO with flush; a pop frees a slot for a same-cycle push.
module rc4_ks_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   logic [W-1:0] mem [DEPTH];
   logic [AW:0] wp, rp;
   logic do_push, do_pop;
   assign empty = wp == rp;
   assign full = wp == {~rp[AW], rp[AW-1:0]};
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout = empty ? '0 : mem[rp[AW-1:0]];
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wp <= '0;
         rp <= '0;
      end else begin
         wp <= wp + PW'(do_push);
         rp <= rp + PW'(do_pop);
      end
   end
   always_ff @(posedge clk)
      if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/rc4_keystream_ctrl.sv
// rc4_keystream_ctrl: loads the key into the rc4 core and buffers len keystream bytes for a consumer.
// Define RC4_CTRL_DROP_EN to discard the first DROP_N core bytes of every run (RC4-drop[N]).
module rc4_keystream_ctrl
   import rc4_ctrl_pkg::*;
#(
   parameter int KEY_SIZE   = rc4_ctrl_pkg::KEY_SIZE,
`ifdef RC4_CTRL_DROP_EN
   parameter int DROP_N     = 256,
`endif
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        key_we,
   input  logic [$clog2(KEY_SIZE)-1:0] key_addr,
   input  logic [7:0]                  key_data,
   input  logic                        start,
   input  logic [CNT_W-1:0]            len,
   input  logic                        abort,
   output logic                        busy,
   output logic                        done,
   output logic                        overflow,
   output logic [7:0]                  ks_data,
   output logic                        ks_valid,
   input  logic                        ks_ready,
   output logic                        ks_last,
   output logic                        core_rst,
   output logic [7:0]                  core_password,
   input  logic                        core_ready,
   input  logic [7:0]                  core_k
);
   localparam int KAW = $clog2(KEY_SIZE);
   state_e state, state_n;
   logic [7:0] key_mem [KEY_SIZE];
   logic [KAW-1:0] idx;
   logic [CNT_W-1:0] len_r, acc_cnt, dlv_cnt;
   logic go, dropping, take, push, pop, full, empty, fin;
   assign go = state == IDLE && start && len != '0 && !abort;
   assign busy = state != IDLE;
   assign ks_valid = !empty;
   assign pop = ks_valid && ks_ready;
   assign take = state == RUN && core_ready && !dropping && acc_cnt != len_r;
   assign push = take && (!full || pop);
   assign fin = (state == RUN || state == DRAIN) && acc_cnt == len_r && dlv_cnt + CNT_W'(pop) == len_r;
   assign ks_last = ks_valid && dlv_cnt + CNT_W'(1) == len_r;
`ifdef RC4_CTRL_DROP_EN
   logic [CNT_W-1:0] drop_cnt;
   assign dropping = drop_cnt < CNT_W'(DROP_N);
   always_ff @(posedge clk) begin
      if (rst || go) drop_cnt <= '0;
      else if (state == RUN && core_ready && dropping) drop_cnt <= drop_cnt + CNT_W'(1);
   end
`else
   assign dropping = 1'b0;
`endif
   always_ff @(posedge clk)
      if (key_we && state == IDLE) key_mem[key_addr] <= key_data;
   always_comb begin
      state_n = state;
      core_rst = !(state == LOAD || state == RUN);
      core_password = state == CRST ? key_mem[0] : state == LOAD ? key_mem[idx] : 8'h00;
      case (state)
         IDLE:       state_n = go ? CRST : IDLE;
         CRST:       state_n = LOAD;
         LOAD:       state_n = idx == KAW'(KEY_SIZE - 1) ? RUN : LOAD;
         RUN, DRAIN: state_n = fin ? IDLE : acc_cnt == len_r ? DRAIN : state;
         default:    state_n = IDLE;
      endcase
      if (abort) state_n = IDLE;
   end
   // a core byte that finds the FIFO full (with no pop freeing a slot) is lost for good
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx <= '0;
         len_r <= '0;
         acc_cnt <= '0;
         dlv_cnt <= '0;
         overflow <= 1'b0;
         done <= 1'b0;
      end else begin
         state <= state_n;
         done <= state != IDLE && (abort || fin);
         idx <= state == LOAD ? idx + KAW'(1) : '0;
         len_r <= go ? len : len_r;
         acc_cnt <= go ? '0 : acc_cnt + CNT_W'(push);
         dlv_cnt <= go ? '0 : dlv_cnt + CNT_W'(pop);
         overflow <= !go && (overflow || (take && full && !pop));
      end
   end
   rc4_ks_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
      .clk(clk),
      .rst(rst),
      .flush(abort),
      .push(push),
      .pop(pop),
      .din(core_k),
      .dout(ks_data),
      .full(full),
      .empty(empty)
   );
endmodule

// File: tb/tb_rc4_keystream_ctrl.sv
// tb_rc4_keystream_ctrl: drives the controller against a behavioural rc4 core stand-in
// and compares delivered bytes with a software RC4 keystream of the bench's own key.
module tb_rc4_keystream_ctrl;
   localparam int KS = rc4_ctrl_pkg::KEY_SIZE;
   localparam int AW = $clog2(KS);
`ifdef RC4_CTRL_DROP_EN
   localparam int OFS = 256;
`else
   localparam int OFS = 0;
`endif
   typedef logic [7:0] key_t [KS];
   typedef logic [7:0] bq_t [$];
   logic clk = 0, rst = 1, key_we = 0, start = 0, abort = 0, ks_ready = 0, core_ready = 0;
   logic [AW-1:0] key_addr = '0;
   logic [7:0] key_data = 0, core_k = 0;
   logic [15:0] len = 0;
   logic busy, done, overflow, ks_valid, ks_last, core_rst;
   logic [7:0] ks_data, core_password;
   int tests = 0, fails = 0;
   key_t tb_key, pw;
   bq_t core_q, got, exp_q;
   logic lasts [$];
   int dones = 0, cap = 0, rdy_pct = 100;

   always #5 clk = ~clk;

   rc4_keystream_ctrl #(.KEY_SIZE(KS), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .key_we(key_we), .key_addr(key_addr), .key_data(key_data),
      .start(start), .len(len), .abort(abort), .busy(busy), .done(done), .overflow(overflow),
      .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_last(ks_last),
      .core_rst(core_rst), .core_password(core_password), .core_ready(core_ready), .core_k(core_k)
   );

   function automatic bq_t rc4_gen(input key_t k, input int n);
      logic [7:0] s [256];
      logic [7:0] t;
      int i = 0, j = 0;
      bq_t q;
      for (int x = 0; x < 256; x++) s[x] = x[7:0];
      for (int x = 0; x < 256; x++) begin
         j = (j + s[x] + k[x % KS]) % 256;
         t = s[x]; s[x] = s[j]; s[j] = t;
      end
      j = 0;
      for (int x = 0; x < n; x++) begin
         i = (i + 1) % 256;
         j = (j + s[i]) % 256;
         t = s[i]; s[i] = s[j]; s[j] = t;
         q.push_back(s[(s[i] + s[j]) % 256]);
      end
      return q;
   endfunction

   // consumer monitor plus core stand-in: captures KS password bytes out of reset, then streams
   always @(negedge clk) begin
      if (ks_valid && ks_ready) begin
         got.push_back(ks_data);
         lasts.push_back(ks_last);
      end
      if (done) dones++;
      if (core_rst) begin
         cap = 0;
         core_ready = 0;
         core_q.delete();
      end else if (cap < KS) begin
         pw[cap] = core_password;
         cap++;
         core_ready = 0;
         if (cap == KS) core_q = rc4_gen(pw, 1024);
      end else begin
         core_ready = core_q.size() > 0 && $urandom_range(99) < rdy_pct;
         if (core_ready) core_k = core_q.pop_front();
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load_key(input bit rnd);
      for (int a = 0; a < KS; a++) begin
         tb_key[a] = rnd ? 8'($urandom) : 8'h42;
         key_we = 1;
         key_addr = AW'(a);
         key_data = tb_key[a];
         tick();
      end
      key_we = 0;
   endtask

   task automatic kick(input int n);
      got.delete();
      lasts.delete();
      dones = 0;
      exp_q = rc4_gen(tb_key, OFS + n);
      start = 1;
      len = 16'(n);
      tick();
      start = 0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 0;
      for (int c = 0; c < budget; c++) begin
         if (dones > 0) begin
            ok = 1;
            break;
         end
         tick();
      end
      tick(3);
   endtask

   task automatic test_reset();
      rst = 1;
      tick(2);
      @(negedge clk);
      tests++; if ({busy, done, overflow, ks_valid, ks_last} !== 5'b0) begin fails++; $display("FAIL reset_flags: got %b want 00000", {busy, done, overflow, ks_valid, ks_last}); end
      tests++; if (ks_data !== 8'h00) begin fails++; $display("FAIL reset_ks_data: got %02h want 00", ks_data); end
      tests++; if ({core_rst, core_password} !== 9'h100) begin fails++; $display("FAIL reset_core: got rst=%b pw=%02h want rst=1 pw=00", core_rst, core_password); end
      rst = 0;
      tick();
   endtask

   task automatic test_basic();
      bit ok;
      int nl;
      load_key(0);
      ks_ready = 1;
      rdy_pct = $urandom_range(100, 40);
      kick(16);
      wait_idle(3000, ok);
      tests++; if (!ok) begin fails++; $display("FAIL basic_timeout: got no done want done"); end
      tests++; if (got.size() !== 16) begin fails++; $display("FAIL basic_count: got %0d want 16", got.size()); end
      foreach (got[k]) begin
         tests++; if (got[k] !== exp_q[OFS + k]) begin fails++; $display("FAIL basic_data[%0d]: got %02h want %02h", k, got[k], exp_q[OFS + k]); end
      end
      nl = 0;
      foreach (lasts[k]) nl += int'(lasts[k]);
      tests++; if (nl !== 1 || lasts[lasts.size() - 1] !== 1'b1) begin fails++; $display("FAIL basic_last: got %0d last flags, final=%b want 1, final=1", nl, lasts[lasts.size() - 1]); end
      tests++; if (dones !== 1) begin fails++; $display("FAIL basic_done: got %0d pulses want 1", dones); end
      tests++; if ({overflow, busy} !== 2'b00) begin fails++; $display("FAIL basic_idle: got ovf=%b busy=%b want 0 0", overflow, busy); end
   endtask

   task automatic test_load_seq();
      bit ok;
      load_key(1);
      rdy_pct = 100;
      ks_ready = 1;
      kick(4);
      @(negedge clk);
      tests++; if ({core_rst, core_password} !== {1'b1, tb_key[0]}) begin fails++; $display("FAIL load_crst: got rst=%b pw=%02h want rst=1 pw=%02h", core_rst, core_password, tb_key[0]); end
      for (int i = 0; i < KS; i++) begin
         @(negedge clk);
         tests++; if ({core_rst, core_password} !== {1'b0, tb_key[i]}) begin fails++; $display("FAIL load_byte[%0d]: got rst=%b pw=%02h want rst=0 pw=%02h", i, core_rst, core_password, tb_key[i]); end
      end
      wait_idle(3000, ok);
      tests++; if (!ok || got.size() !== 4) begin fails++; $display("FAIL load_run: got done=%b count=%0d want done=1 count=4", ok, got.size()); end
      foreach (got[k]) begin
         tests++; if (got[k] !== exp_q[OFS + k]) begin fails++; $display("FAIL load_data[%0d]: got %02h want %02h", k, got[k], exp_q[OFS + k]); end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      load_key(1);
      rdy_pct = 100;
      ks_ready = 1;
      kick(24);
      for (int c = 0; c < 2000 && got.size() < 2; c++) tick();
      ks_ready = 0;
      tick(10);
      ks_ready = 1;
      wait_idle(3000, ok);
      tests++; if (!ok) begin fails++; $display("FAIL bp_timeout: got no done want done"); end
      tests++; if (got.size() !== 24) begin fails++; $display("FAIL bp_count: got %0d want 24", got.size()); end
      tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL bp_overflow: got %b want 1", overflow); end
      tests++; if (got[0] !== exp_q[OFS]) begin fails++; $display("FAIL bp_first: got %02h want %02h", got[0], exp_q[OFS]); end
      kick(8);
      @(negedge clk);
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL bp_ovf_clear: got %b want 0", overflow); end
      wait_idle(3000, ok);
      tests++; if (!ok || got.size() !== 8) begin fails++; $display("FAIL bp_rerun: got done=%b count=%0d want done=1 count=8", ok, got.size()); end
      foreach (got[k]) begin
         tests++; if (got[k] !== exp_q[OFS + k]) begin fails++; $display("FAIL bp_rerun_data[%0d]: got %02h want %02h", k, got[k], exp_q[OFS + k]); end
      end
   endtask

   task automatic test_abort();
      bit ok;
      load_key(1);
      rdy_pct = 100;
      ks_ready = 1;
      kick(8);
      tick(3);
      @(negedge clk);
      tests++; if ({busy, core_rst} !== 2'b10) begin fails++; $display("FAIL abort_in_load: got busy=%b core_rst=%b want 1 0", busy, core_rst); end
      abort = 1;
      tick();
      abort = 0;
      @(negedge clk);
      tests++; if ({done, ks_valid, core_rst, busy} !== 4'b1010) begin fails++; $display("FAIL abort_state: got done,valid,crst,busy=%b want 1010", {done, ks_valid, core_rst, busy}); end
      tick(3);
      tests++; if (dones !== 1) begin fails++; $display("FAIL abort_done_count: got %0d want 1", dones); end
      kick(12);
      wait_idle(3000, ok);
      tests++; if (!ok || got.size() !== 12) begin fails++; $display("FAIL abort_rerun: got done=%b count=%0d want done=1 count=12", ok, got.size()); end
      foreach (got[k]) begin
         tests++; if (got[k] !== exp_q[OFS + k]) begin fails++; $display("FAIL abort_rerun_data[%0d]: got %02h want %02h", k, got[k], exp_q[OFS + k]); end
      end
   endtask

   task automatic test_corner();
      bit ok;
      dones = 0;
      start = 1;
      len = 0;
      tick();
      start = 0;
      tick(3);
      @(negedge clk);
      tests++; if (busy !== 1'b0 || dones !== 0) begin fails++; $display("FAIL len0: got busy=%b dones=%0d want 0 0", busy, dones); end
      abort = 1;
      tick();
      abort = 0;
      tick(2);
      tests++; if (dones !== 0) begin fails++; $display("FAIL idle_abort: got %0d done pulses want 0", dones); end
      load_key(1);
      rdy_pct = $urandom_range(100, 50);
      ks_ready = 1;
      kick(16);
      for (int c = 0; c < 2000 && got.size() < 1; c++) tick();
      for (int a = 0; a < KS; a++) begin
         key_we = 1;
         key_addr = AW'(a);
         key_data = ~tb_key[a];
         tick();
      end
      key_we = 0;
      wait_idle(3000, ok);
      kick(16);
      wait_idle(3000, ok);
      tests++; if (!ok || got.size() !== 16) begin fails++; $display("FAIL keywe_run: got done=%b count=%0d want done=1 count=16", ok, got.size()); end
      foreach (got[k]) begin
         tests++; if (got[k] !== exp_q[OFS + k]) begin fails++; $display("FAIL keywe_data[%0d]: got %02h want %02h", k, got[k], exp_q[OFS + k]); end
      end
   endtask

`ifdef RC4_CTRL_DROP_EN
   task automatic test_drop();
      bit ok;
      load_key(1);
      rdy_pct = $urandom_range(100, 60);
      ks_ready = 1;
      kick(4);
      wait_idle(5000, ok);
      tests++; if (!ok || got.size() !== 4) begin fails++; $display("FAIL drop_run: got done=%b count=%0d want done=1 count=4", ok, got.size()); end
      foreach (got[k]) begin
         tests++; if (got[k] !== exp_q[256 + k]) begin fails++; $display("FAIL drop_data[%0d]: got %02h want %02h", k, got[k], exp_q[256 + k]); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_load_seq();
      test_backpressure();
      test_abort();
      test_corner();
`ifdef RC4_CTRL_DROP_EN
      test_drop();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
